// File: rtl/disp_pkg.sv
// Shared types, defaults and anode helper for the 7-segment scan controller.
// Latency: none (declarations only). Backpressure: not applicable.
// Optional feature elsewhere: DISP_LEADING_ZERO_BLANK_EN.
package disp_pkg;

    localparam int DISP_N_DIGITS_DEF    = 4;
    localparam int DISP_REFRESH_DIV_DEF = 27000;
    localparam int DISP_MAX_DIGITS      = 8;

    typedef logic [3:0] nibble_t;

    // Active-low one-cold anode pattern for digit idx out of n digits.
    function automatic logic [DISP_MAX_DIGITS-1:0] onecold_an(input int unsigned idx,
                                                             input int unsigned n);
        logic [DISP_MAX_DIGITS-1:0] an;
        an = '1;
        for (int unsigned k = 0; k < DISP_MAX_DIGITS; k++) begin
            if ((k == idx) && (k < n)) begin
                an[k] = 1'b0;
            end
        end
        return an;
    endfunction

endpackage

// File: rtl/module_disp_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the last count as tick.
// Latency: tick is combinational from the registered count. Backpressure: none, free-running.
module module_disp_tick #(
    parameter int REFRESH_DIV = 27000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/module_disp_scan.sv
// Time-multiplexed N-digit common-anode scan controller; values swap only on frame boundaries.
// Latency: outputs registered, one cycle behind idx/disp_q; accept-to-display <= one frame + 1 cycle.
// Backpressure: ready_o low while a value is pending; optional DISP_LEADING_ZERO_BLANK_EN blanks leading zeros.
module module_disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = DISP_N_DIGITS_DEF,
    parameter int REFRESH_DIV = DISP_REFRESH_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output nibble_t               nibble_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int IW = $clog2(N_DIGITS);

    logic [IW-1:0]              idx;
    logic                       tick;
    logic                       frame_edge;
    logic                       accept;
    logic [4*N_DIGITS-1:0]      disp_q;
    logic [4*N_DIGITS-1:0]      pend_q;
    logic                       pend_v;
    logic [N_DIGITS-1:0]        blank;
    logic                       zero_run;
    logic [DISP_MAX_DIGITS-1:0] an_full;
    nibble_t                    nib_nxt;
    logic [N_DIGITS-1:0]        an_nxt;

    module_disp_tick #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign ready_o    = !pend_v;
    assign accept     = valid_i && !pend_v;
    assign frame_edge = tick && (idx == IW'(N_DIGITS - 1));

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; digit 0 is never blanked.
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0);
            blank[k] = zero_run;
        end
`endif
    end

    always_comb begin
        an_full = onecold_an(32'(idx), N_DIGITS);
        an_nxt  = an_full[N_DIGITS-1:0];
        nib_nxt = disp_q[4*idx +: 4];
        if (blank[idx]) begin
            an_nxt  = '1;
            nib_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v   <= 1'b0;
            nibble_o <= '0;
            an_o     <= '1;
            frame_o  <= 1'b0;
        end else begin
            if (tick) begin
                idx <= frame_edge ? '0 : idx + IW'(1);
            end
            // accept needs pend_v == 0, so it never collides with a pending swap.
            if (accept) begin
                pend_q <= value_i;
                pend_v <= 1'b1;
            end else if (frame_edge && pend_v) begin
                disp_q <= pend_q;
                pend_v <= 1'b0;
            end
            nibble_o <= nib_nxt;
            an_o     <= an_nxt;
            frame_o  <= frame_edge;
        end
    end

endmodule

// File: tb/tb_module_disp_scan.sv
// Bench for module_disp_scan (N_DIGITS=4, REFRESH_DIV=4): directed plan plus random traffic vs a cycle-count model.
// Honours DISP_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_module_disp_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value_i;
    logic          valid_i;
    logic          ready_o;
    logic [3:0]    nibble_o;
    logic [3:0]    an_o;
    logic          frame_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: edges since reset, displayed/pending values, expected registered outputs.
    int          m_c;
    logic [15:0] m_disp, m_pend;
    logic        m_pendv;
    logic [3:0]  e_nib, e_an;
    logic        e_frame;

    module_disp_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (value_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .nibble_o(nibble_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_edge(input logic r, input logic v, input logic [15:0] val,
                                       output logic acc);
        int  slot_idx;
        logic bnd;
        acc = 1'b0;
        if (!r) begin
            m_c = 0; m_disp = '0; m_pend = '0; m_pendv = 1'b0;
            e_nib = '0; e_an = 4'hF; e_frame = 1'b0;
        end else begin
            slot_idx = (m_c / DIV) % N;
            bnd      = ((m_c + 1) % (N * DIV)) == 0;
            e_nib    = 4'((m_disp >> (4 * slot_idx)) & 16'hF);
            e_an     = ~(4'b0001 << slot_idx);
`ifdef DISP_LEADING_ZERO_BLANK_EN
            if (slot_idx > 0 && (m_disp >> (4 * slot_idx)) == 16'h0) begin
                e_an  = 4'hF;
                e_nib = 4'h0;
            end
`endif
            e_frame = bnd;
            if (v && !m_pendv) begin
                m_pend = val; m_pendv = 1'b1; acc = 1'b1;
            end else if (bnd && m_pendv) begin
                m_disp = m_pend; m_pendv = 1'b0;
            end
            m_c++;
        end
    endfunction

    // One clock: check outputs at the negedge, drive inputs, advance model to next posedge.
    task automatic step(input logic r, input logic v, input logic [15:0] val, output logic acc);
        @(negedge clk);
        chk("nibble", 32'(nibble_o), 32'(e_nib));
        chk("an",     32'(an_o),     32'(e_an));
        chk("frame",  32'(frame_o),  32'(e_frame));
        chk("ready",  32'(ready_o),  32'(!m_pendv));
        rst_n   = r;
        valid_i = v;
        value_i = val;
        model_edge(r, v, val, acc);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, a);
    endtask

    task automatic offer(input logic [15:0] val, input int budget);
        logic a;
        a = 1'b0;
        for (int i = 0; i < budget && !a; i++) step(1'b1, 1'b1, val, a);
        if (!a) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        a;
        logic        holding;
        logic [15:0] hold_val;
        int          lead;

        rst_n = 1'b0; valid_i = 1'b0; value_i = '0;
        repeat (3) @(posedge clk);
        model_edge(1'b0, 1'b0, 16'h0, a);

        idle(40);
        offer(16'h1A3F, 4);
        offer(16'hBEEF, 40);
        idle(40);

        // Wait for the edge that is a frame boundary, then offer on it.
        for (int i = 0; i < 32 && ((m_c + 1) % (N * DIV)) != 0; i++) idle(1);
        chk("bnd_aligned", 32'(((m_c + 1) % (N * DIV))), 32'd0);
        step(1'b1, 1'b1, 16'h5A5A, a);
        chk("bnd_accept", 32'(a), 32'd1);
        idle(40);

        step(1'b1, 1'b1, 16'h7777, a);
        step(1'b1, 1'b0, 16'h0, a);
        step(1'b0, 1'b0, 16'h0, a);
        step(1'b0, 1'b0, 16'h0, a);
        idle(40);

        offer(16'h0042, 40);
        idle(40);
        offer(16'h0000, 40);
        idle(40);
        offer(16'h0300, 40);
        idle(40);

        holding  = 1'b0;
        hold_val = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                step(1'b0, 1'b0, 16'h0, a);
                holding = 1'b0;
            end else begin
                if (!holding && $urandom_range(0, 3) == 0) begin
                    lead     = $urandom_range(0, 4);
                    hold_val = 16'($urandom()) & 16'(32'hFFFF >> (4 * lead));
                    holding  = 1'b1;
                end
                step(1'b1, holding, holding ? hold_val : 16'($urandom()), a);
                if (a) holding = 1'b0;
            end
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
